// File: rtl/avalon16_read_master_pkg.sv
// Shared definitions for the avalon16_read_master block.
//   ST_*        : FSM state encodings (IDLE / ISSUE / DRAIN)
//   BYTEEN_FULL : byteenable for a full 16-bit access
//   WORD_BYTES  : byte stride between consecutive 16-bit words
package avalon16_read_master_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam logic [1:0] BYTEEN_FULL = 2'b11;
  localparam int         WORD_BYTES  = 2;

endpackage

// File: rtl/avalon16_read_master_sync_fifo16.sv
// sync_fifo16: single-clock show-ahead FIFO of 16-bit words.
//   clock, resetn : clock, asynchronous active-low reset
//   push/push_data: write a word (ignored only when full with no pop)
//   pop           : consume the head word (ignored when empty)
//   head          : current head word, 0 while empty
//   valid         : FIFO non-empty
//   count         : number of stored words (0..DEPTH)
module sync_fifo16 #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   head,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so push at full is still honoured.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon16_read_master.sv
// avalon16_read_master: fetches word_count 16-bit words starting at base_addr
// over Avalon-MM pipelined reads and streams them out through a local FIFO.
//   clock, resetn                 : clock, asynchronous active-low reset
//   start, base_addr, word_count  : command (sampled only when idle)
//   busy, done                    : status; done pulses when the last word lands
//   address, read, byteenable     : Avalon request side
//   readdata, waitrequest,
//   readdatavalid                 : Avalon response / flow control
//   out_data, out_valid, out_ready: output stream
//   state_dbg                     : current FSM state for observation
//
// Handshakes: an Avalon read transfers on a cycle with read=1 and
// waitrequest=0; address/read stay stable while waitrequest is high.
// A stream word transfers on a cycle with out_valid=1 and out_ready=1;
// out_valid/out_data never depend on out_ready.
module avalon16_read_master
  import avalon16_read_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic [1:0]        byteenable,
  input  logic [15:0]       readdata,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        state_dbg
);

  localparam int PW  = $clog2(MAX_PENDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] responded;
  logic [PW-1:0]    pending;
  logic [FCW-1:0]   fifo_count;
  logic [31:0]      occupancy;
  logic             credit;
  logic             accept;
  logic             rsp;
  logic             last_accept;
  logic             last_rsp;
  logic             unused_ok;

  // Bit 0 of the byte address is forced to zero (word aligned).
  assign unused_ok = base_addr[0];

  // Every slot that is either in flight or buffered is reserved in the FIFO,
  // so a response always finds room. During a stall neither term can grow,
  // hence read never drops mid-stall.
  assign occupancy = 32'(pending) + 32'(fifo_count);
  assign credit    = (occupancy < 32'(FIFO_DEPTH)) && (32'(pending) < 32'(MAX_PENDING));

  assign read        = (state == ST_ISSUE) && (issued != count_q) && credit;
  assign accept      = read && !waitrequest;
  // Responses are only meaningful while a transfer owns outstanding reads;
  // stale ones (e.g. after a reset) are dropped without touching counters.
  assign rsp         = readdatavalid && (state != ST_IDLE) && (pending != '0);
  assign last_accept = accept && ((issued + 1'b1) == count_q);
  assign last_rsp    = rsp && ((responded + 1'b1) == count_q);

  assign busy       = (state != ST_IDLE);
  assign byteenable = BYTEEN_FULL;
  assign state_dbg  = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      count_q   <= '0;
      issued    <= '0;
      responded <= '0;
      pending   <= '0;
      address   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              state     <= ST_ISSUE;
              count_q   <= word_count;
              address   <= {base_addr[ADDR_W-1:1], 1'b0};
              issued    <= '0;
              responded <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (last_accept) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_rsp) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // accept and rsp are both 0 in IDLE, so these never collide with the
      // command latch above.
      if (accept) begin
        address <= address + ADDR_W'(WORD_BYTES);
        issued  <= issued + 1'b1;
      end
      if (rsp) responded <= responded + 1'b1;

      case ({accept, rsp})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  sync_fifo16 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (rsp),
    .push_data (readdata),
    .pop       (out_valid && out_ready),
    .head      (out_data),
    .valid     (out_valid),
    .count     (fifo_count)
  );

endmodule
